// File: rtl/frame_buffer_reader.sv
// Raster-order reader for the frame buffer BRAM: issues word reads, buffers up to two
// words to hide the registered read latency, and streams the unpacked pixels out.
module frame_buffer_reader #(
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter int PIXEL_WIDTH     = 3,
    parameter int PIXELS_PER_WORD = 6,
    parameter int FRAME_WORDS     = RAM_DEPTH,
    localparam int ADDR_W         = $clog2(RAM_DEPTH - 1),
    localparam int IDX_W          = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1
) (
    input  logic                   clka,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   frame_start_i,
    output logic                   ram_en_o,
    output logic                   ram_we_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    input  logic [RAM_WIDTH-1:0]   ram_dout_i,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i,
    output logic [PIXEL_WIDTH-1:0] pix_data_o,
    output logic                   pix_last_o
);

    logic [ADDR_W-1:0]    r_rd_addr;
    logic [1:0]           r_occ;
    logic                 r_inflight;
    logic                 r_inflight_last;
    logic [RAM_WIDTH-1:0] r_word0;
    logic [RAM_WIDTH-1:0] r_word1;
    logic                 r_last0;
    logic                 r_last1;
    logic [IDX_W-1:0]     r_pix_idx;

    logic                   w_valid;
    logic                   w_idx_end;
    logic                   w_xfer;
    logic                   w_pop;
    logic [2:0]             w_level;
    logic                   w_issue;
    logic                   w_issue_last;
    logic [1:0]             w_slot;
    logic [PIXEL_WIDTH-1:0] w_pix;

    assign w_valid      = (r_occ != 2'd0);
    assign w_idx_end    = (r_pix_idx == IDX_W'(PIXELS_PER_WORD - 1));
    assign w_xfer       = w_valid & pix_ready_i;
    assign w_pop        = w_xfer & w_idx_end;
    // Counting the word being popped this cycle lets a read issue early enough for 1 pixel/cycle.
    assign w_level      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = ~rst & en_i & ~frame_start_i & (w_level < 3'd2);
    assign w_issue_last = (r_rd_addr == ADDR_W'(FRAME_WORDS - 1));
    assign w_slot       = r_occ - {1'b0, w_pop};

    // Select the current pixel of the head word; zero while nothing is buffered.
    always_comb begin
        w_pix = '0;
        if (w_valid) begin
            w_pix = r_word0[int'(r_pix_idx) * PIXEL_WIDTH +: PIXEL_WIDTH];
        end else begin
            w_pix = '0;
        end
    end

    assign ram_en_o    = w_issue;
    assign ram_we_o    = 1'b0;
    assign ram_addr_o  = r_rd_addr;
    assign pix_valid_o = w_valid;
    assign pix_data_o  = w_pix;
    assign pix_last_o  = w_valid & r_last0 & w_idx_end;

    // Read address, in-flight tracking, two-entry word buffer and pixel index.
    always_ff @(posedge clka) begin
        if (rst) begin
            r_rd_addr       <= '0;
            r_occ           <= 2'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_word0         <= '0;
            r_word1         <= '0;
            r_last0         <= 1'b0;
            r_last1         <= 1'b0;
            r_pix_idx       <= '0;
        end else if (frame_start_i) begin
            r_rd_addr       <= '0;
            r_occ           <= 2'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_pix_idx       <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_addr       <= w_issue_last ? '0 : r_rd_addr + ADDR_W'(1);
                r_inflight_last <= w_issue_last;
            end
            if (w_pop) begin
                r_word0   <= r_word1;
                r_last0   <= r_last1;
                r_pix_idx <= '0;
            end else if (w_xfer) begin
                r_pix_idx <= r_pix_idx + IDX_W'(1);
            end
            // Capture lands behind whatever survives this cycle's pop.
            if (r_inflight) begin
                if (w_slot == 2'd0) begin
                    r_word0 <= ram_dout_i;
                    r_last0 <= r_inflight_last;
                end else begin
                    r_word1 <= ram_dout_i;
                    r_last1 <= r_inflight_last;
                end
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule
